// File: rtl/xs3_to_bcd_serial.sv
// Serial Excess-3 to packed BCD decoder: one XS3 digit per handshake, MS digit first,
// DIGITS digits packed into one word presented on a valid/ready output port.
module xs3_to_bcd_serial #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_digit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic [7:0]            err_count
);

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          legal;
    logic [3:0]    mapped;

    always_comb begin
        legal  = (in_digit >= 4'h3) && (in_digit <= 4'hC);
        mapped = legal ? (in_digit - 4'h3) : 4'hF;
    end

    // in_ready/out_valid are registered so they never depend combinationally on inputs,
    // and in_ready stays low for the whole time reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            count     <= '0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            err_count <= '0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        out_bcd <= {out_bcd[4*DIGITS-5:0], mapped};
                        if (!legal) begin
                            out_err <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end
                        if (count == CW'(DIGITS - 1)) begin
                            count     <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_to_bcd_serial.sv
// Self-checking bench for xs3_to_bcd_serial (DIGITS=4) against a word-level
// arithmetic reference model.
module tb_xs3_to_bcd_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_err;
    logic [7:0]  err_count;

    int n_cmp;
    int n_bad;
    int err_model;

    xs3_to_bcd_serial #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {word_err, bcd} for four XS3 digits packed MS digit first.
    function automatic logic [16:0] ref_word(input logic [15:0] xs3);
        int unsigned acc;
        int unsigned d;
        logic        e;
        acc = 0;
        e   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = xs3[i*4 +: 4];
            if (d >= 3 && d <= 12) begin
                acc = acc * 16 + (d - 3);
            end else begin
                acc = acc * 16 + 15;
                e   = 1'b1;
            end
        end
        return {e, 16'(acc)};
    endfunction

    function automatic int count_illegal(input logic [15:0] xs3);
        int n;
        int unsigned d;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            d = xs3[i*4 +: 4];
            if (d < 3 || d > 12) n++;
        end
        return n;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    // Drive one digit and return just after the edge that accepts it.
    task automatic send_digit(input logic [3:0] d);
        int n;
        in_valid = 1'b1;
        in_digit = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] xs3);
        for (int i = 3; i >= 0; i--) send_digit(xs3[i*4 +: 4]);
        err_model = sat_add(err_model, count_illegal(xs3));
    endtask

    task automatic take_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        err_model = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++;
        if (out_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_out_bcd: got %h want 0000", out_bcd); end
        n_cmp++;
        if (err_count !== 8'h00) begin n_bad++; $display("FAIL reset_err_count: got %h want 00", err_count); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++;
        if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
        rst = 1'b0;
        err_model = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_legal_word();
        logic [16:0] exp;
        exp = ref_word(16'hC6A3);
        send_word(16'hC6A3);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL legal_latency: out_valid=%0b want 1", out_valid); end
        n_cmp++;
        if (out_bcd !== exp[15:0]) begin n_bad++; $display("FAIL legal_bcd: got %h want %h", out_bcd, exp[15:0]); end
        n_cmp++;
        if (out_err !== exp[16]) begin n_bad++; $display("FAIL legal_err: got %0b want %0b", out_err, exp[16]); end
        take_word();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL legal_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] exp;
        exp = ref_word(16'h4156);
        send_word(16'h4156);
        n_cmp++;
        if (out_bcd !== exp[15:0] || out_err !== exp[16]) begin
            n_bad++;
            $display("FAIL illegal_word: got %h/%0b want %h/%0b", out_bcd, out_err, exp[15:0], exp[16]);
        end
        n_cmp++;
        if (err_count !== 8'(err_model)) begin n_bad++; $display("FAIL illegal_count: got %0d want %0d", err_count, err_model); end
        take_word();
        exp = ref_word(16'h7777);
        send_word(16'h7777);
        n_cmp++;
        if (out_bcd !== exp[15:0] || out_err !== exp[16]) begin
            n_bad++;
            $display("FAIL clean_after_err: got %h/%0b want %h/%0b", out_bcd, out_err, exp[15:0], exp[16]);
        end
        n_cmp++;
        if (err_count !== 8'(err_model)) begin n_bad++; $display("FAIL clean_count: got %0d want %0d", err_count, err_model); end
        take_word();
    endtask

    task automatic test_backpressure();
        logic [16:0] exp;
        exp = ref_word(16'hC6A3);
        send_word(16'hC6A3);
        in_valid = 1'b1;
        in_digit = 4'hE;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_bcd !== exp[15:0] || in_ready !== 1'b0 || err_count !== 8'(err_model)) begin
                n_bad++;
                $display("FAIL backpressure_hold[%0d]: v=%0b bcd=%h rdy=%0b cnt=%0d want 1/%h/0/%0d",
                         c, out_valid, out_bcd, in_ready, err_count, exp[15:0], err_model);
            end
        end
        in_valid = 1'b0;
        take_word();
        exp = ref_word(16'hE333);
        send_word(16'hE333);
        n_cmp++;
        if (out_bcd !== exp[15:0] || out_err !== exp[16] || err_count !== 8'(err_model)) begin
            n_bad++;
            $display("FAIL backpressure_resume: got %h/%0b/%0d want %h/%0b/%0d",
                     out_bcd, out_err, err_count, exp[15:0], exp[16], err_model);
        end
        take_word();
    endtask

    task automatic test_reset_mid_word();
        logic [16:0] exp;
        send_digit(4'hC);
        send_digit(4'hC);
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_bcd !== 16'h0000) begin
            n_bad++;
            $display("FAIL midreset_clear: v=%0b bcd=%h want 0/0000", out_valid, out_bcd);
        end
        exp = ref_word(16'h3456);
        send_word(16'h3456);
        n_cmp++;
        if (out_valid !== 1'b1 || out_bcd !== exp[15:0] || out_err !== exp[16]) begin
            n_bad++;
            $display("FAIL midreset_word: v=%0b got %h/%0b want %h/%0b", out_valid, out_bcd, out_err, exp[15:0], exp[16]);
        end
        take_word();
    endtask

    task automatic test_random();
        logic [16:0] exp;
        logic [15:0] w;
        int unsigned delay;
        for (int k = 0; k < 20; k++) begin
            w = 16'($urandom);
            exp = ref_word(w);
            send_word(w);
            delay = $urandom_range(0, 3);
            repeat (delay) @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_bcd !== exp[15:0] || out_err !== exp[16] || err_count !== 8'(err_model)) begin
                n_bad++;
                $display("FAIL random_word[%0d] xs3=%h: v=%0b got %h/%0b/%0d want %h/%0b/%0d",
                         k, w, out_valid, out_bcd, out_err, err_count, exp[15:0], exp[16], err_model);
            end
            take_word();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 65; k++) begin
            send_word(16'h0000);
            n_cmp++;
            if (err_count !== 8'(err_model)) begin
                n_bad++;
                $display("FAIL saturation[%0d]: got %0d want %0d", k, err_count, err_model);
            end
            take_word();
        end
        n_cmp++;
        if (err_count !== 8'hFF) begin n_bad++; $display("FAIL saturation_final: got %h want ff", err_count); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        err_model = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_legal_word();
        test_illegal();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
